// File: rtl/chicken_pkg.sv
// Shared state encoding and index helper for the chicken-race datapath.
package chicken_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SCAN      = 3'd1,
      WAIT_CARD = 3'd2,
      MOVE      = 3'd3,
      NEXT      = 3'd4,
      WIN       = 3'd5
   } state_e;

   // (v + 1) mod m, valid for v < m
   function automatic int unsigned mod_inc(input int unsigned v, input int unsigned m);
      return (v + 32'd1 >= m) ? 32'd0 : v + 32'd1;
   endfunction

endpackage

// File: rtl/chicken_target_scan.sv
// Sequential occupancy scanner: one probe per cycle from pos[cur]+1 until a free tile is found,
// recording every chicken jumped on the way.
module chicken_target_scan
   import chicken_pkg::*;
#(
   parameter  int unsigned NUM_PLAYERS = 4,
   parameter  int unsigned NUM_TILES   = 24,
   localparam int unsigned POS_W       = $clog2(NUM_TILES),
   localparam int unsigned PW          = $clog2(NUM_PLAYERS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         scan_i,
   input  logic                         start_i,
   input  logic [PW-1:0]                cur_i,
   input  logic [NUM_PLAYERS*POS_W-1:0] pos_flat_i,
   output logic                         done_c_o,
   output logic [POS_W-1:0]             target_o,
   output logic [NUM_PLAYERS-1:0]       jump_mask_o
);

   logic [POS_W-1:0]       pos_c [NUM_PLAYERS];
   logic [POS_W-1:0]       probe_c;
   logic [NUM_PLAYERS-1:0] hit_c;
   logic [POS_W-1:0]       cand_q, cand_d;
   logic [POS_W-1:0]       target_q, target_d;
   logic [NUM_PLAYERS-1:0] mask_q, mask_d;

   // The first probe comes straight from the mover's position; later probes from cand_q.
   always_comb begin
      cand_d   = cand_q;
      target_d = target_q;
      mask_d   = mask_q;
      done_c_o = 1'b0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         pos_c[i] = pos_flat_i[i*POS_W +: POS_W];
      end
      probe_c = start_i ? POS_W'(mod_inc(32'(pos_c[cur_i]), NUM_TILES)) : cand_q;
      for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
         hit_c[j] = (PW'(j) != cur_i) && (pos_c[j] == probe_c);
      end
      if (scan_i) begin
         mask_d = start_i ? '0 : mask_q;
         if (|hit_c) begin
            mask_d = mask_d | hit_c;
            cand_d = POS_W'(mod_inc(32'(probe_c), NUM_TILES));
         end else begin
            done_c_o = 1'b1;
            target_d = probe_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand_q   <= '0;
         target_q <= '0;
         mask_q   <= '0;
      end else begin
         cand_q   <= cand_d;
         target_q <= target_d;
         mask_q   <= mask_d;
      end
   end

   assign target_o    = target_q;
   assign jump_mask_o = mask_q;

endmodule

// File: rtl/chicken_race_datapath.sv
// Chicken-race game datapath: tile track, positions, turn pointer, move and win detection.
// Optional build macro FEATHER_STEAL_EN: jumped chickens hand their feathers to the mover.
module chicken_race_datapath
   import chicken_pkg::*;
#(
   parameter  int unsigned NUM_PLAYERS = 4,
   parameter  int unsigned NUM_TILES   = 24,
   parameter  int unsigned PIC_W       = 4,
   parameter  int unsigned WIN_LAPS    = 2,
   localparam int unsigned POS_W       = $clog2(NUM_TILES),
   localparam int unsigned PW          = $clog2(NUM_PLAYERS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tile_wr_en,
   input  logic [POS_W-1:0]             tile_wr_addr,
   input  logic [PIC_W-1:0]             tile_wr_pic,
   input  logic                         start,
   input  logic                         card_valid,
   input  logic [PIC_W-1:0]             card_pic,
   output logic                         card_ready,
   output logic [PW-1:0]                cur_player,
   output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
   output logic                         go,
   output logic                         miss,
   output logic                         win,
   output logic [PW-1:0]                winner
);

   localparam int unsigned SPACING = NUM_TILES / NUM_PLAYERS;

   state_e                 state_q, state_d;
   logic [PW-1:0]          cur_q, cur_d;
   logic [POS_W-1:0]       pos_q [NUM_PLAYERS];
   logic [POS_W-1:0]       pos_d [NUM_PLAYERS];
   logic [PIC_W-1:0]       tile_q [NUM_TILES];
   logic                   scan_start_q;
   logic                   scan_done_c;
   logic                   win_c;
   logic                   go_q, miss_q, ready_q, win_q;
   logic [PW-1:0]          winner_q;
   logic [POS_W-1:0]       target;
   logic [NUM_PLAYERS-1:0] jump_mask;

`ifdef FEATHER_STEAL_EN
   localparam int unsigned FW = $clog2(NUM_PLAYERS + 1);
   logic [FW-1:0] feath_q [NUM_PLAYERS];
   logic [FW-1:0] feath_d [NUM_PLAYERS];
`else
   localparam int unsigned LAP_W = $clog2(WIN_LAPS + 1);
   logic [LAP_W-1:0] laps_q [NUM_PLAYERS];
   logic [LAP_W-1:0] laps_d [NUM_PLAYERS];
   logic             unused_jump_mask;
   assign unused_jump_mask = ^jump_mask;
`endif

   chicken_target_scan #(
      .NUM_PLAYERS (NUM_PLAYERS),
      .NUM_TILES   (NUM_TILES)
   ) u_scan (
      .clk         (clk),
      .rst         (rst),
      .scan_i      (state_q == SCAN),
      .start_i     (scan_start_q),
      .cur_i       (cur_q),
      .pos_flat_i  (pos_flat),
      .done_c_o    (scan_done_c),
      .target_o    (target),
      .jump_mask_o (jump_mask)
   );

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      pos_d   = pos_q;
      win_c   = 1'b0;
`ifdef FEATHER_STEAL_EN
      feath_d = feath_q;
`else
      laps_d  = laps_q;
`endif
      unique case (state_q)
         IDLE: if (start) state_d = SCAN;
         SCAN: if (scan_done_c) state_d = WAIT_CARD;
         WAIT_CARD: begin
            if (card_valid) state_d = (card_pic == tile_q[target]) ? MOVE : NEXT;
         end
         MOVE: begin
            pos_d[cur_q] = target;
`ifdef FEATHER_STEAL_EN
            for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
               if (jump_mask[j]) begin
                  feath_d[cur_q] = feath_d[cur_q] + feath_q[j];
                  feath_d[j]     = '0;
               end
            end
            win_c = (feath_d[cur_q] == FW'(NUM_PLAYERS));
`else
            // A target behind the old position means the chicken passed tile 0.
            if ((target < pos_q[cur_q]) && (laps_q[cur_q] != LAP_W'(WIN_LAPS))) begin
               laps_d[cur_q] = laps_q[cur_q] + LAP_W'(1);
            end
            win_c = (laps_d[cur_q] == LAP_W'(WIN_LAPS));
`endif
            state_d = win_c ? WIN : SCAN;
         end
         NEXT: begin
            cur_d   = PW'(mod_inc(32'(cur_q), NUM_PLAYERS));
            state_d = SCAN;
         end
         WIN: state_d = WIN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cur_q        <= '0;
         scan_start_q <= 1'b0;
         go_q         <= 1'b0;
         miss_q       <= 1'b0;
         ready_q      <= 1'b0;
         win_q        <= 1'b0;
         winner_q     <= '0;
         for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            pos_q[i] <= POS_W'(i * SPACING);
`ifdef FEATHER_STEAL_EN
            feath_q[i] <= FW'(1);
`else
            laps_q[i] <= '0;
`endif
         end
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         pos_q        <= pos_d;
`ifdef FEATHER_STEAL_EN
         feath_q      <= feath_d;
`else
         laps_q       <= laps_d;
`endif
         scan_start_q <= (state_d == SCAN) && (state_q != SCAN);
         go_q         <= (state_d == MOVE);
         miss_q       <= (state_d == NEXT);
         ready_q      <= (state_d == WAIT_CARD);
         win_q        <= (state_d == WIN);
         if (state_d == WIN) winner_q <= cur_d;
      end
   end

   // Tile pictures survive reset; writes land only while idle.
   always_ff @(posedge clk) begin
      if (tile_wr_en && (state_q == IDLE)) tile_q[tile_wr_addr] <= tile_wr_pic;
   end

   always_comb begin
      pos_flat = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         pos_flat[i*POS_W +: POS_W] = pos_q[i];
      end
   end

   assign card_ready = ready_q;
   assign cur_player = cur_q;
   assign go         = go_q;
   assign miss       = miss_q;
   assign win        = win_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_chicken_race_datapath.sv
// Randomised self-checking bench for chicken_race_datapath against a board-level game model.
module tb_chicken_race_datapath;

   localparam int NP       = 4;
   localparam int NT       = 24;
   localparam int PIC_W    = 4;
   localparam int WIN_LAPS = 2;
   localparam int POS_W    = 5;
   localparam int PW       = 2;

   logic                  clk;
   logic                  rst;
   logic                  tile_wr_en;
   logic [POS_W-1:0]      tile_wr_addr;
   logic [PIC_W-1:0]      tile_wr_pic;
   logic                  start;
   logic                  card_valid;
   logic [PIC_W-1:0]      card_pic;
   logic                  card_ready;
   logic [PW-1:0]         cur_player;
   logic [NP*POS_W-1:0]   pos_flat;
   logic                  go;
   logic                  miss;
   logic                  win;
   logic [PW-1:0]         winner;

   chicken_race_datapath #(
      .NUM_PLAYERS (NP),
      .NUM_TILES   (NT),
      .PIC_W       (PIC_W),
      .WIN_LAPS    (WIN_LAPS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tile_wr_en   (tile_wr_en),
      .tile_wr_addr (tile_wr_addr),
      .tile_wr_pic  (tile_wr_pic),
      .start        (start),
      .card_valid   (card_valid),
      .card_pic     (card_pic),
      .card_ready   (card_ready),
      .cur_player   (cur_player),
      .pos_flat     (pos_flat),
      .go           (go),
      .miss         (miss),
      .win          (win),
      .winner       (winner)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Board model: where every chicken stands, how far it has walked, whose turn it is.
   int m_pos  [NP];
   int m_dist [NP];
   int m_tile [NT];
   int m_cur;
   bit m_won;
`ifdef FEATHER_STEAL_EN
   int m_feath [NP];
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_pos[i]  = i * (NT / NP);
         m_dist[i] = 0;
`ifdef FEATHER_STEAL_EN
         m_feath[i] = 1;
`endif
      end
      m_cur = 0;
      m_won = 1'b0;
   endtask

   function automatic logic [NP*POS_W-1:0] exp_flat();
      logic [NP*POS_W-1:0] f;
      for (int i = 0; i < NP; i++) f[i*POS_W +: POS_W] = POS_W'(m_pos[i]);
      return f;
   endfunction

   // Entered on the first SCAN cycle; plays one card and leaves on the next SCAN (or WIN) cycle.
   task automatic do_card(input bit force_en, input int force_pic, output bit won);
      int tgt, own, n, pic;
      int jumped[$];
      bit match;
      tgt = (m_pos[m_cur] + 1) % NT;
      forever begin
         own = -1;
         for (int j = 0; j < NP; j++) if (j != m_cur && m_pos[j] == tgt) own = j;
         if (own < 0) break;
         jumped.push_back(own);
         tgt = (tgt + 1) % NT;
      end
      n = 0;
      while (card_ready !== 1'b1 && n < 4 * NP) begin
         tick();
         n++;
      end
      vectors++;
      if (card_ready !== 1'b1 || n != jumped.size() + 1) begin
         miscompares++;
         $display("FAIL scan_latency: player %0d ready=%b after %0d cycles, expected ready after %0d",
                  m_cur, card_ready, n, jumped.size() + 1);
      end
      if (force_en) pic = force_pic;
      else if ($urandom % 4 != 0) pic = m_tile[tgt];
      else pic = int'($urandom % 16);
      match      = (pic == m_tile[tgt]);
      card_valid = 1'b1;
      card_pic   = PIC_W'(pic);
      tick();
      card_valid = 1'b0;
      vectors++;
      if (go !== match || miss !== !match) begin
         miscompares++;
         $display("FAIL card_result: go=%b miss=%b, expected go=%b miss=%b (tile %0d pic %0d card %0d)",
                  go, miss, match, !match, tgt, m_tile[tgt], pic);
      end
      if (match) begin
         m_dist[m_cur] += (tgt - m_pos[m_cur] + NT) % NT;
         m_pos[m_cur]   = tgt;
`ifdef FEATHER_STEAL_EN
         foreach (jumped[k]) begin
            m_feath[m_cur]    += m_feath[jumped[k]];
            m_feath[jumped[k]] = 0;
         end
         m_won = (m_feath[m_cur] == NP);
`else
         m_won = ((m_cur * (NT / NP) + m_dist[m_cur]) / NT) >= WIN_LAPS;
`endif
      end else begin
         m_cur = (m_cur + 1) % NP;
      end
      tick();
      vectors++;
      if (go !== 1'b0 || miss !== 1'b0 || card_ready !== 1'b0 || pos_flat !== exp_flat() ||
          cur_player !== PW'(m_cur) || win !== m_won || (m_won && winner !== PW'(m_cur))) begin
         miscompares++;
         $display("FAIL after_card: go=%b miss=%b rdy=%b pos=%h cur=%0d win=%b winner=%0d, expected pos=%h cur=%0d win=%b",
                  go, miss, card_ready, pos_flat, cur_player, win, winner, exp_flat(), m_cur, m_won);
      end
      won = m_won;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (card_ready !== 1'b0 || go !== 1'b0 || miss !== 1'b0 || win !== 1'b0 ||
          winner !== '0 || cur_player !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl: rdy=%b go=%b miss=%b win=%b winner=%0d cur=%0d, expected all 0",
                  card_ready, go, miss, win, winner, cur_player);
      end
      vectors++;
      if (pos_flat !== exp_flat()) begin
         miscompares++;
         $display("FAIL reset_pos: got %h expected %h", pos_flat, exp_flat());
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      vectors++;
      if (card_ready !== 1'b0 || pos_flat !== exp_flat() || cur_player !== '0) begin
         miscompares++;
         $display("FAIL idle_after_reset: rdy=%b pos=%h cur=%0d, expected rdy=0 pos=%h cur=0",
                  card_ready, pos_flat, cur_player, exp_flat());
      end
   endtask

   task automatic test_load_start();
      bit w;
      for (int k = 0; k < NT; k++) begin
         m_tile[k]    = k % 12;
         tile_wr_en   = 1'b1;
         tile_wr_addr = POS_W'(k);
         tile_wr_pic  = PIC_W'(k % 12);
         tick();
      end
      tile_wr_en = 1'b0;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      do_card(1'b1, 1, w);
      do_card(1'b1, 5, w);
   endtask

   task automatic test_wr_outside_idle();
      bit w;
      int tgt;
      tgt          = (m_pos[m_cur] + 1) % NT;
      tile_wr_en   = 1'b1;
      tile_wr_addr = POS_W'(tgt);
      tile_wr_pic  = PIC_W'((m_tile[tgt] + 1) % 16);
      do_card(1'b1, m_tile[tgt], w);
      tile_wr_en   = 1'b0;
   endtask

   task automatic test_reset_mid_scan();
      bit w;
      rst = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (card_ready !== 1'b0 || go !== 1'b0 || miss !== 1'b0 || win !== 1'b0 ||
          cur_player !== '0 || pos_flat !== exp_flat()) begin
         miscompares++;
         $display("FAIL reset_mid_scan: rdy=%b go=%b miss=%b win=%b cur=%0d pos=%h, expected pos=%h",
                  card_ready, go, miss, win, cur_player, pos_flat, exp_flat());
      end
      card_valid = 1'b1;
      card_pic   = PIC_W'(m_tile[1]);
      tick();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (card_ready !== 1'b0 || go !== 1'b0 || miss !== 1'b0 || pos_flat !== exp_flat()) begin
            miscompares++;
            $display("FAIL idle_ignores_card: rdy=%b go=%b miss=%b pos=%h, expected 0 0 0 %h",
                     card_ready, go, miss, pos_flat, exp_flat());
         end
      end
      card_valid = 1'b0;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      do_card(1'b1, m_tile[1], w);
   endtask

   task automatic test_random_game(output bit won);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      model_reset();
      for (int k = 0; k < NT; k++) begin
         m_tile[k]    = int'($urandom % 16);
         tile_wr_en   = 1'b1;
         tile_wr_addr = POS_W'(k);
         tile_wr_pic  = PIC_W'(m_tile[k]);
         tick();
      end
      tile_wr_en = 1'b0;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      won        = 1'b0;
      for (int t = 0; t < 3000 && !won; t++) do_card(1'b0, 0, won);
      vectors++;
      if (!won) begin
         miscompares++;
         $display("FAIL game_end: win=%b after card budget, expected a winner", win);
      end
   endtask

   task automatic test_win_hold();
      logic [NP*POS_W-1:0] frozen;
      frozen = exp_flat();
      for (int c = 0; c < 8; c++) begin
         card_valid   = 1'b1;
         card_pic     = PIC_W'($urandom % 16);
         start        = 1'b1;
         tile_wr_en   = 1'b1;
         tile_wr_addr = POS_W'($urandom % NT);
         tile_wr_pic  = PIC_W'($urandom % 16);
         tick();
         vectors++;
         if (win !== 1'b1 || winner !== PW'(m_cur) || card_ready !== 1'b0 || go !== 1'b0 ||
             miss !== 1'b0 || pos_flat !== frozen) begin
            miscompares++;
            $display("FAIL win_hold: win=%b winner=%0d rdy=%b go=%b miss=%b pos=%h, expected 1 %0d 0 0 0 %h",
                     win, winner, card_ready, go, miss, pos_flat, m_cur, frozen);
         end
      end
      card_valid = 1'b0;
      start      = 1'b0;
      tile_wr_en = 1'b0;
   endtask

   initial begin
      bit won;
      clk          = 1'b0;
      rst          = 1'b1;
      tile_wr_en   = 1'b0;
      tile_wr_addr = '0;
      tile_wr_pic  = '0;
      start        = 1'b0;
      card_valid   = 1'b0;
      card_pic     = '0;
      test_reset();
      test_load_start();
      test_wr_outside_idle();
      test_reset_mid_scan();
      test_random_game(won);
      if (won) test_win_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
